// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: widths, program-RAM state encoding and mode constants. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Shared with the PC counter: it stalls while model_sel is MODE_PROG.
  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_PROG = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ERASE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_sp.sv
// ---------------------------------------------------------------------------
// ram_sp: single-port synchronous RAM, write enable, registered read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_sp
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Read register holds its value whenever re is low.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/prog_ram.sv
// ---------------------------------------------------------------------------
// prog_ram: program memory with run-read and erase/load FSM. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_ram
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              model_sel,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              busy,
  output logic              prog_done,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic              rd_valid_d, rd_valid_q;
  logic              wr_ready_d, wr_ready_q;
  logic              prog_done_d, prog_done_q;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ptr_inc;
  logic              beat;

  assign ptr_inc = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_valid_d  = 1'b0;
    wr_ready_d  = wr_ready_q;
    prog_done_d = prog_done_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = wr_ptr_q;
    ram_wdata   = '0;
    beat        = 1'b0;

    case (state_q)
      ST_RUN: begin
        ram_addr = addr;
        if (model_sel == MODE_PROG) begin
          state_d  = ST_ERASE;
          wr_ptr_d = '0;
        end else begin
          ram_re     = 1'b1;
          rd_valid_d = 1'b1;
        end
      end

      ST_ERASE: begin
        ram_we   = 1'b1;
        wr_ptr_d = ptr_inc;
        if (wr_ptr_q == PTR_MAX) begin
          state_d    = ST_LOAD;
          wr_ready_d = 1'b1;
        end
      end

      ST_LOAD: begin
        beat = wr_valid && wr_ready_q;
        if (beat) begin
          ram_we    = 1'b1;
          ram_wdata = wr_data;
          wr_ptr_d  = ptr_inc;
        end
        // Abort wins over completion; a beat in the abort cycle still lands.
        if (model_sel == MODE_RUN) begin
          state_d     = ST_RUN;
          wr_ready_d  = 1'b0;
          prog_done_d = 1'b0;
        end else if (beat && (wr_last || wr_ptr_q == PTR_MAX)) begin
          state_d     = ST_DONE;
          wr_ready_d  = 1'b0;
          prog_done_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (model_sel == MODE_RUN) begin
          state_d     = ST_RUN;
          prog_done_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
      prog_done_q <= prog_done_d;
    end
  end

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign wr_ready  = wr_ready_q;
  assign prog_done = prog_done_q;
  assign busy      = (state_q != ST_RUN);
  assign wr_ptr    = wr_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_ram.sv
// ---------------------------------------------------------------------------
// tb_prog_ram: randomized self-checking bench for prog_ram. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_ram;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       model_sel;
  logic [7:0] addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_ready;
  logic       busy;
  logic       prog_done;
  logic [7:0] wr_ptr;

  int checks = 0;
  int errors = 0;

  // Reference memory: contents plus whether each byte is known yet.
  logic [7:0] model_mem   [DEPTH];
  bit         model_known [DEPTH];
  int         model_ptr;

  prog_ram dut (
    .clk       (clk),
    .reset     (reset),
    .model_sel (model_sel),
    .addr      (addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .prog_done (prog_done),
    .wr_ptr    (wr_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enters programming mode and waits (bounded) for the load phase.
  task automatic do_erase();
    int n = 0;
    model_sel = 1'b1;
    wr_valid  = 1'b0;
    wr_last   = 1'b0;
    tick();
    while (wr_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL erase_timeout: wr_ready=%b after %0d cycles, required 1", wr_ready, n);
    end
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = 8'h00;
      model_known[i] = 1'b1;
    end
    model_ptr = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    model_mem[model_ptr] = d;
    model_ptr = (model_ptr + 1) % DEPTH;
  endtask

  task automatic test_reset();
    reset = 1'b0; model_sel = 1'b0; addr = 8'h00;
    wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
    tick();
    tick();
    checks++;
    if ({rd_data, rd_valid, wr_ready, busy, prog_done, wr_ptr} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: rd_data=%h rd_valid=%b wr_ready=%b busy=%b prog_done=%b wr_ptr=%h, required all 0",
               rd_data, rd_valid, wr_ready, busy, prog_done, wr_ptr);
    end
    reset = 1'b1;
    addr  = 8'h05;
    #2;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_rd_valid_low: rd_valid=%b, required 0", rd_valid);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL release_rd_valid_high[%0d]: rd_valid=%b, required 1", k, rd_valid);
      end
    end
  endtask

  task automatic test_erase();
    int n = 0;
    model_sel = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || wr_ptr !== 8'h00 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL erase_entry: busy=%b wr_ready=%b wr_ptr=%h rd_valid=%b, required 1 0 00 0",
               busy, wr_ready, wr_ptr, rd_valid);
    end
    while (wr_ready === 1'b0 && n < 1000) begin
      n++;
      tick();
    end
    checks++;
    if (n != DEPTH || wr_ptr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL erase_duration: cycles=%0d wr_ptr=%h busy=%b, required 256 00 1", n, wr_ptr, busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = 8'h00;
      model_known[i] = 1'b1;
    end
    model_ptr = 0;
    model_sel = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || prog_done !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL erase_exit: busy=%b prog_done=%b rd_valid=%b, required 0 0 0", busy, prog_done, rd_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      addr = 8'(i);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_mem[i]) begin
        errors++;
        $display("FAIL erase_read[%0d]: rd_data=%h rd_valid=%b, required %h 1", i, rd_data, rd_valid, model_mem[i]);
      end
    end
  endtask

  task automatic test_load3();
    do_erase();
    send_beat(8'hA1, 1'b0);
    tick();
    send_beat(8'hB2, 1'b0);
    tick();
    send_beat(8'hC3, 1'b1);
    checks++;
    if (prog_done !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b1 || wr_ptr !== 8'h03) begin
      errors++;
      $display("FAIL load3_done: prog_done=%b wr_ready=%b busy=%b wr_ptr=%h, required 1 0 1 03",
               prog_done, wr_ready, busy, wr_ptr);
    end
    model_sel = 1'b0;
    tick();
    checks++;
    if (prog_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load3_return: prog_done=%b busy=%b, required 0 0", prog_done, busy);
    end
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_mem[i]) begin
        errors++;
        $display("FAIL load3_read[%0d]: rd_data=%h rd_valid=%b, required %h 1", i, rd_data, rd_valid, model_mem[i]);
      end
    end
  endtask

  task automatic test_abort();
    do_erase();
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    model_sel = 1'b0;
    send_beat(8'h33, 1'b0);
    checks++;
    if (busy !== 1'b0 || prog_done !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b prog_done=%b wr_ready=%b rd_valid=%b, required 0 0 0 0",
               busy, prog_done, wr_ready, rd_valid);
    end
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_mem[i]) begin
        errors++;
        $display("FAIL abort_read[%0d]: rd_data=%h rd_valid=%b, required %h 1", i, rd_data, rd_valid, model_mem[i]);
      end
    end
  endtask

  task automatic test_full_load();
    do_erase();
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      if (i == 128) begin
        checks++;
        if (wr_ptr !== 8'd128 || prog_done !== 1'b0 || wr_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_mid: wr_ptr=%h prog_done=%b wr_ready=%b, required 80 0 1", wr_ptr, prog_done, wr_ready);
        end
      end
      send_beat(8'($urandom_range(1, 255)), 1'b0);
    end
    checks++;
    if (prog_done !== 1'b1 || wr_ptr !== 8'h00 || wr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_done: prog_done=%b wr_ptr=%h wr_ready=%b busy=%b, required 1 00 0 1",
               prog_done, wr_ptr, wr_ready, busy);
    end
    model_sel = 1'b0;
    tick();
    addr = 8'hFF;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== model_mem[255]) begin
      errors++;
      $display("FAIL full_read_ff: rd_data=%h, required %h", rd_data, model_mem[255]);
    end
    for (int k = 0; k < 64; k++) begin
      int a;
      a = int'($urandom_range(0, DEPTH - 1));
      addr = 8'(a);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_mem[a]) begin
        errors++;
        $display("FAIL full_read[%0d]: rd_data=%h rd_valid=%b, required %h 1", a, rd_data, rd_valid, model_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid_erase();
    model_sel = 1'b1;
    tick();
    repeat (100) tick();
    checks++;
    if (wr_ptr !== 8'd100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_erase_ptr: wr_ptr=%h busy=%b, required 64 1", wr_ptr, busy);
    end
    for (int i = 0; i < 100; i++) model_mem[i] = 8'h00;
    reset     = 1'b0;
    model_sel = 1'b0;
    tick();
    checks++;
    if ({rd_data, rd_valid, wr_ready, busy, prog_done, wr_ptr} !== 21'd0) begin
      errors++;
      $display("FAIL mid_erase_reset: rd_data=%h rd_valid=%b wr_ready=%b busy=%b prog_done=%b wr_ptr=%h, required all 0",
               rd_data, rd_valid, wr_ready, busy, prog_done, wr_ptr);
    end
    reset = 1'b1;
    addr  = 8'h10;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_erase_read_10: rd_data=%h rd_valid=%b, required 00 1", rd_data, rd_valid);
    end
    addr = 8'hF0;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== model_mem[8'hF0]) begin
      errors++;
      $display("FAIL mid_erase_read_f0: rd_data=%h rd_valid=%b, required %h 1", rd_data, rd_valid, model_mem[8'hF0]);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = 8'h00;
      model_known[i] = 1'b0;
    end
    model_ptr = 0;
    test_reset();
    test_erase();
    test_load3();
    test_abort();
    test_full_load();
    test_reset_mid_erase();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_ram.md
Name: prog_ram

Overview:
- Program memory on the far end of the PC address bus. Consumes the 8-bit address driven by the PC counter and returns the stored instruction byte with registered read.
- Owns the erase/write side of the mode select:
  - model_sel=1 erases the whole array.
  - It then accepts a byte stream through a valid/ready handshake.
  - It reports completion.
- Sits between the PC counter and instruction decode.

Parameters:
- ADDR_W, 8, address width; must match the PC width.
- DATA_W, 8, instruction/data byte width.
- DEPTH, 2**ADDR_W, number of words.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- model_sel  input  1  mode: 0 = run (read), 1 = erase/write.
- addr  input  ADDR_W  read address from the PC counter.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  rd_data corresponds to addr sampled on the previous edge.
- wr_valid  input  1  loader presents wr_data.
- wr_data  input  DATA_W  byte to store at the internal write pointer.
- wr_last  input  1  marks the final byte of the load; qualified by wr_valid.
- wr_ready  output  1  block accepts a byte this cycle.
- busy  output  1  high in ERASE, LOAD and DONE.
- prog_done  output  1  load finished; held until return to RUN.
- wr_ptr  output  ADDR_W  current erase/write address, for debug and status.

Behaviour:
- Reset (reset==0 at the clock edge):
  - state=RUN.
  - rd_data=0, rd_valid=0, wr_ready=0, busy=0, prog_done=0, wr_ptr=0.
  - Array contents are not reset.
  - Reset overrides everything, including mid-ERASE and mid-LOAD. A partially erased or loaded array is left as-is.
- Next-state logic: FSM states are RUN, ERASE, LOAD, DONE, encoded as 2 bits.
- RUN:
  - Each cycle rd_data<=mem[addr] and rd_valid<=1, giving 1-cycle latency.
  - rd_valid first rises on the first edge after entering RUN.
  - If model_sel==1: go to ERASE, wr_ptr<=0, rd_valid<=0, busy<=1. rd_data holds its last value.
- ERASE:
  - Each cycle mem[wr_ptr]<=0 and wr_ptr<=wr_ptr+1. wr_ready=0.
  - After writing wr_ptr==DEPTH-1, go to LOAD with wr_ptr wrapping to 0. Total duration is exactly DEPTH cycles.
  - ERASE always runs to completion, regardless of model_sel.
- LOAD:
  - wr_ready=1 (registered; high from the first LOAD cycle).
  - A beat is accepted when wr_valid && wr_ready: mem[wr_ptr]<=wr_data, wr_ptr<=wr_ptr+1.
  - If the accepted beat has wr_last=1, or wr_ptr==DEPTH-1: go to DONE, prog_done<=1, wr_ready<=0. wr_ptr wraps to 0 in the full case.
  - If model_sel==0 (abort):
    - Any beat accepted in the same cycle is still written.
    - Then go to RUN with prog_done=0 and busy=0.
    - The array holds the erased contents plus any bytes loaded so far.
  - wr_last with wr_valid=0 is ignored.
- DONE:
  - wr_ready=0, prog_done=1, busy=1.
  - When model_sel==0: go to RUN, prog_done<=0, busy<=0.
- Address arithmetic: wr_ptr is modulo DEPTH and never exceeds DEPTH-1. The array is written only in ERASE and LOAD.
- No read occurs while busy. The addr input is ignored outside RUN.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W/DATA_W defaults.
  - The state enum (ST_RUN, ST_ERASE, ST_LOAD, ST_DONE).
  - Mode constants MODE_RUN=0 and MODE_PROG=1, shared with the PC counter.
- One sub-module, ram_sp: single-port synchronous array with registered read and a write enable.
- prog_ram contains the FSM, the pointer and the port mux into ram_sp.

Test Plan:
- Reset, then run: hold reset=0 for 2 cycles, then release with model_sel=0 and addr=0x05.
  - rd_valid=0 in the first cycle after release, then 1 thereafter.
  - Before any load, rd_data=mem[5] (unknown).
- Full erase: assert model_sel=1 and count cycles.
  - busy rises next edge; wr_ready=0 for exactly 256 cycles; then wr_ready=1.
  - After returning to RUN, every address reads 0x00.
- Load 3 bytes: send 0xA1, 0xB2, 0xC3 with wr_last on 0xC3; deassert wr_valid between beats.
  - prog_done=1 the cycle after 0xC3 and wr_ready=0.
  - After model_sel=0: addr 0,1,2,3 read 0xA1, 0xB2, 0xC3, 0x00, each one cycle after the address is applied.
- Full-depth load: 256 beats with no wr_last.
  - DONE is entered after beat 255 and wr_ptr wraps to 0.
  - Reading 0xFF returns beat 255's data.
- Abort mid-load: after 2 beats (0x11, 0x22), drop model_sel in the same cycle as a third beat 0x33.
  - 0x33 is written to addr 2; state returns to RUN with prog_done=0.
  - addr 3 reads 0x00.
- Reset mid-erase: assert reset=0 at erase cycle 100.
  - All outputs return to reset values the next edge; state is RUN.
  - addr 0x10 reads 0x00 and addr 0xF0 keeps its previous contents.
